// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N:1 stream mux.
// Select-width helper and packet-mode encodings.
package mux_pkg;

  localparam int MODE_BEAT = 0;
  localparam int MODE_PKT  = 1;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Double-width priority scan starting at ptr; lock narrows to one channel.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          lock,
  input  logic [SW-1:0] lock_ch,
  output logic [N-1:0]  gnt_onehot,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [N-1:0]   elig;
  logic [2*N-1:0] req2;

  always_comb begin
    elig = req;
    if (lock) elig = req & (N'(1) << lock_ch);
  end

  assign req2 = {elig, elig};

  // Window [ptr, ptr+N) of the doubled vector is the rotated request set.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (!gnt_any && req2[j] &&
          j >= int'(ptr) && j < int'(ptr) + N) begin
        gnt_any             = 1'b1;
        gnt_idx             = SW'(j % N);
        gnt_onehot[j % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_n_1.sv
// Round-robin N:1 stream mux with registered output.
// Optional packet mode holds the grant until the granted channel's last beat.
module rr_mux_n_1
  import mux_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = 3,
  parameter int PKT_MODE = MODE_BEAT,
  parameter int SW       = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [SW-1:0]   out_sel
);

  logic [SW-1:0] ptr;
  logic          lock;
  logic [SW-1:0] lock_ch;
  logic [N-1:0]  gnt_onehot;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  sel_data;
  logic          sel_last;
  logic [SW-1:0] ptr_nxt;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .lock       (lock),
    .lock_ch    (lock_ch),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign load_en  = !out_valid || out_ready;
  assign xfer     = load_en && gnt_any;
  assign in_ready = (xfer && rst_n) ? gnt_onehot : '0;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gnt_onehot[k]) begin
        sel_data = sel_data | in_data[k*W +: W];
        sel_last = sel_last | in_last[k];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_sel   <= gnt_idx;
        if (PKT_MODE == MODE_PKT && !sel_last) begin
          lock    <= 1'b1;
          lock_ch <= gnt_idx;
        end else begin
          lock    <= 1'b0;
          ptr     <= ptr_nxt;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n_1.sv
// Directed bench for rr_mux_n_1: beat mode N=8, packet mode N=8,
// and beat mode N=5 with a small scoreboard.
module tb_rr_mux_n_1;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_err;

  // beat mode, N=8, W=3
  logic [7:0]  m_valid, m_ready_in, m_last;
  logic [23:0] m_data;
  logic        m_ovalid, m_oready, m_olast;
  logic [2:0]  m_odata, m_osel;

  // packet mode, N=8, W=3
  logic [7:0]  p_valid, p_ready_in, p_last;
  logic [23:0] p_data;
  logic        p_ovalid, p_oready, p_olast;
  logic [2:0]  p_odata, p_osel;

  // beat mode, N=5, W=4
  logic [4:0]  n_valid, n_ready_in, n_last;
  logic [19:0] n_data;
  logic        n_ovalid, n_oready, n_olast;
  logic [3:0]  n_odata;
  logic [2:0]  n_osel;

  rr_mux_n_1 #(.N(8), .W(3), .PKT_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_valid), .in_ready(m_ready_in),
    .in_data(m_data), .in_last(m_last),
    .out_valid(m_ovalid), .out_ready(m_oready),
    .out_data(m_odata), .out_last(m_olast), .out_sel(m_osel)
  );

  rr_mux_n_1 #(.N(8), .W(3), .PKT_MODE(1)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p_valid), .in_ready(p_ready_in),
    .in_data(p_data), .in_last(p_last),
    .out_valid(p_ovalid), .out_ready(p_oready),
    .out_data(p_odata), .out_last(p_olast), .out_sel(p_osel)
  );

  rr_mux_n_1 #(.N(5), .W(4), .PKT_MODE(0)) u_n5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_valid), .in_ready(n_ready_in),
    .in_data(n_data), .in_last(n_last),
    .out_valid(n_ovalid), .out_ready(n_oready),
    .out_data(n_odata), .out_last(n_olast), .out_sel(n_osel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n5_cnt [5];
  logic [3:0] sb_q [$];
  logic [15:0] seen;
  logic [3:0] exp_d;
  int es;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    m_valid = '1; m_last = '0; m_oready = 1'b1;
    for (int k = 0; k < 8; k++) m_data[k*3 +: 3] = 3'(k);
    p_valid = '0; p_last = '0; p_data = '0; p_oready = 1'b1;
    n_valid = '0; n_last = '0; n_data = '0; n_oready = 1'b1;
    #2;
    chk("rst_valid", 32'(m_ovalid), 0);
    chk("rst_sel", 32'(m_osel), 0);
    chk("rst_ready", 32'(m_ready_in), 0);
    step();
    step();
    rst_n = 1'b1;

    // all valid, full throughput
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr_valid", 32'(m_ovalid), 1);
      chk("rr_sel", 32'(m_osel), i % 8);
      chk("rr_data", 32'(m_odata), i % 8);
    end

    // async reset mid-stream, no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_ovalid), 0);
    chk("arst_sel", 32'(m_osel), 0);
    chk("arst_data", 32'(m_odata), 0);
    chk("arst_ready", 32'(m_ready_in), 0);
    step();
    rst_n = 1'b1;

    // backpressure
    step();
    chk("bp_first", 32'(m_osel), 0);
    m_oready = 1'b0;
    #1;
    chk("bp_ready0", 32'(m_ready_in), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(m_ovalid), 1);
      chk("bp_sel", 32'(m_osel), 0);
      chk("bp_data", 32'(m_odata), 0);
      chk("bp_ready", 32'(m_ready_in), 0);
    end
    m_oready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(m_ready_in), 32'h02);
    step();
    chk("bp_rel_sel", 32'(m_osel), 1);
    chk("bp_rel_data", 32'(m_odata), 1);
    step();
    chk("bp_next_sel", 32'(m_osel), 2);

    // sparse: ch2, ch6 with ptr=3
    m_valid = 8'h44;
    step();
    chk("sp_sel_a", 32'(m_osel), 6);
    chk("sp_data_a", 32'(m_odata), 6);
    step();
    chk("sp_sel_b", 32'(m_osel), 2);
    step();
    chk("sp_sel_c", 32'(m_osel), 6);
    m_valid = 8'h00;
    step();
    chk("idle_valid", 32'(m_ovalid), 0);
    chk("idle_sel", 32'(m_osel), 6);
    chk("idle_data", 32'(m_odata), 6);

    // packet mode: single ch0 beat moves ptr to 1
    p_valid = 8'h01;
    p_last = 8'h01;
    p_data[0 +: 3] = 3'd3;
    step();
    chk("pk_ch0_sel", 32'(p_osel), 0);
    chk("pk_ch0_last", 32'(p_olast), 1);
    p_valid = 8'h13;
    p_last = 8'h00;
    p_data[3 +: 3] = 3'd5;
    p_data[12 +: 3] = 3'd4;
    #1;
    chk("pk_ready1", 32'(p_ready_in), 32'h02);
    step();
    chk("pk_b1_sel", 32'(p_osel), 1);
    chk("pk_b1_data", 32'(p_odata), 5);
    chk("pk_b1_last", 32'(p_olast), 0);
    p_valid = 8'h11;
    #1;
    chk("pk_lock_ready", 32'(p_ready_in), 0);
    step();
    chk("pk_gap_valid", 32'(p_ovalid), 0);
    p_valid = 8'h13;
    p_data[3 +: 3] = 3'd6;
    step();
    chk("pk_b2_sel", 32'(p_osel), 1);
    chk("pk_b2_data", 32'(p_odata), 6);
    chk("pk_b2_last", 32'(p_olast), 0);
    p_data[3 +: 3] = 3'd7;
    p_last = 8'h02;
    step();
    chk("pk_b3_sel", 32'(p_osel), 1);
    chk("pk_b3_data", 32'(p_odata), 7);
    chk("pk_b3_last", 32'(p_olast), 1);
    p_last = 8'h00;
    step();
    chk("pk_after_sel", 32'(p_osel), 4);
    chk("pk_after_data", 32'(p_odata), 4);

    // N=5 wrap with scoreboard
    for (int k = 0; k < 5; k++) n5_cnt[k] = 0;
    seen = '0;
    n_valid = 5'h1f;
    for (int i = 0; i < 6; i++) begin
      es = i % 5;
      for (int k = 0; k < 5; k++)
        n_data[k*4 +: 4] = 4'(k + 5 * n5_cnt[k]);
      #1;
      chk("n5_ready", 32'(n_ready_in), 32'(1) << es);
      exp_d = 4'(es + 5 * n5_cnt[es]);
      sb_q.push_back(exp_d);
      step();
      n5_cnt[es]++;
      chk("n5_valid", 32'(n_ovalid), 1);
      chk("n5_sel", 32'(n_osel), es);
      chk("n5_data", 32'(n_odata), 32'(sb_q.pop_front()));
      chk("n5_dup", 32'(seen[n_odata]), 0);
      seen[n_odata] = 1'b1;
    end
    chk("n5_sb_empty", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
